// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions for the core-side memory master: response codes,
// default bus widths and the master FSM state type.
package axi_lite_pkg;

    localparam int unsigned AXI_ADDR_W = 32;
    localparam int unsigned AXI_DATA_W = 64;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        RESP
    } state_t;

endpackage

// File: rtl/axi_lite_mem_master_if.sv
// Five-channel AXI-Lite bus between the memory master (manager) and the SRAM
// responder (subordinate).
interface axi_lite_mem_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
);
    logic                  axi_aw_valid;
    logic                  axi_aw_ready;
    logic [ADDR_W-1:0]     axi_aw_addr;
    logic [2:0]            axi_aw_prot;

    logic                  axi_w_valid;
    logic                  axi_w_ready;
    logic [DATA_W-1:0]     axi_w_data;
    logic [DATA_W/8-1:0]   axi_w_strb;

    logic                  axi_b_valid;
    logic                  axi_b_ready;
    logic [1:0]            axi_b_resp;

    logic                  axi_ar_valid;
    logic                  axi_ar_ready;
    logic [ADDR_W-1:0]     axi_ar_addr;
    logic [2:0]            axi_ar_prot;

    logic                  axi_r_valid;
    logic                  axi_r_ready;
    logic [DATA_W-1:0]     axi_r_data;
    logic [1:0]            axi_r_resp;

    modport master (
        output axi_aw_valid, axi_aw_addr, axi_aw_prot,
        input  axi_aw_ready,
        output axi_w_valid, axi_w_data, axi_w_strb,
        input  axi_w_ready,
        input  axi_b_valid, axi_b_resp,
        output axi_b_ready,
        output axi_ar_valid, axi_ar_addr, axi_ar_prot,
        input  axi_ar_ready,
        input  axi_r_valid, axi_r_data, axi_r_resp,
        output axi_r_ready
    );

    modport slave (
        input  axi_aw_valid, axi_aw_addr, axi_aw_prot,
        output axi_aw_ready,
        input  axi_w_valid, axi_w_data, axi_w_strb,
        output axi_w_ready,
        output axi_b_valid, axi_b_resp,
        input  axi_b_ready,
        input  axi_ar_valid, axi_ar_addr, axi_ar_prot,
        output axi_ar_ready,
        output axi_r_valid, axi_r_data, axi_r_resp,
        input  axi_r_ready
    );

endinterface

// File: rtl/axi_lite_mem_master.sv
// AXI-Lite initiator: converts one single-beat core memory request at a time
// into an AR/R read or AW/W/B write and returns the result on a valid/ready port.
module axi_lite_mem_master
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W = AXI_ADDR_W,
    parameter int unsigned DATA_W = AXI_DATA_W,
    parameter logic [2:0]  PROT   = 3'b000
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,

    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,

    axi_lite_mem_master_if.master axi
);

    state_t state;
    logic   aw_done;
    logic   w_done;
    logic   aw_fire;
    logic   w_fire;

    assign req_ready        = (state == IDLE);
    assign axi.axi_ar_prot  = PROT;
    assign axi.axi_aw_prot  = PROT;
    assign aw_fire          = axi.axi_aw_valid && axi.axi_aw_ready;
    assign w_fire           = axi.axi_w_valid && axi.axi_w_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            aw_done          <= 1'b0;
            w_done           <= 1'b0;
            axi.axi_aw_valid <= 1'b0;
            axi.axi_aw_addr  <= '0;
            axi.axi_w_valid  <= 1'b0;
            axi.axi_w_data   <= '0;
            axi.axi_w_strb   <= '0;
            axi.axi_b_ready  <= 1'b0;
            axi.axi_ar_valid <= 1'b0;
            axi.axi_ar_addr  <= '0;
            axi.axi_r_ready  <= 1'b0;
            resp_valid       <= 1'b0;
            resp_rdata       <= '0;
            resp_err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        axi.axi_aw_addr <= req_addr;
                        axi.axi_ar_addr <= req_addr;
                        axi.axi_w_data  <= req_wdata;
                        axi.axi_w_strb  <= req_wstrb;
                        if (req_wen) begin
                            axi.axi_aw_valid <= 1'b1;
                            axi.axi_w_valid  <= 1'b1;
                            state            <= WR_REQ;
                        end else begin
                            axi.axi_ar_valid <= 1'b1;
                            state            <= RD_ADDR;
                        end
                    end
                end

                RD_ADDR: begin
                    if (axi.axi_ar_ready) begin
                        axi.axi_ar_valid <= 1'b0;
                        axi.axi_r_ready  <= 1'b1;
                        state            <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (axi.axi_r_valid) begin
                        axi.axi_r_ready <= 1'b0;
                        resp_rdata      <= axi.axi_r_data;
                        resp_err        <= (axi.axi_r_resp != RESP_OKAY);
                        resp_valid      <= 1'b1;
                        state           <= RESP;
                    end
                end

                WR_REQ: begin
                    if (aw_fire) begin
                        axi.axi_aw_valid <= 1'b0;
                        aw_done          <= 1'b1;
                    end
                    if (w_fire) begin
                        axi.axi_w_valid <= 1'b0;
                        w_done          <= 1'b1;
                    end
                    // Done flags lag the handshake by a cycle, so OR in this cycle's fire.
                    if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                        axi.axi_b_ready <= 1'b1;
                        state           <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (axi.axi_b_valid) begin
                        axi.axi_b_ready <= 1'b0;
                        aw_done         <= 1'b0;
                        w_done          <= 1'b0;
                        resp_rdata      <= '0;
                        resp_err        <= (axi.axi_b_resp != RESP_OKAY);
                        resp_valid      <= 1'b1;
                        state           <= RESP;
                    end
                end

                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_mem_master.sv
// Directed bench for axi_lite_mem_master; the bench plays the AXI responder
// cycle by cycle and checks outputs one time unit after each rising edge.
module tb_axi_lite_mem_master;
    import axi_lite_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    axi_lite_mem_master_if #(.ADDR_W(32), .DATA_W(64)) bus ();

    axi_lite_mem_master #(.ADDR_W(32), .DATA_W(64), .PROT(3'b000)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .axi        (bus.master)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst valids", {58'd0, bus.axi_aw_valid, bus.axi_w_valid, bus.axi_ar_valid,
                           bus.axi_r_ready, bus.axi_b_ready, resp_valid}, 64'd0);
        chk("rst aw_addr", {32'd0, bus.axi_aw_addr}, 64'd0);
        chk("rst ar_addr", {32'd0, bus.axi_ar_addr}, 64'd0);
        chk("rst w_data", bus.axi_w_data, 64'd0);
        chk("rst w_strb", {56'd0, bus.axi_w_strb}, 64'd0);
        chk("rst resp", {resp_rdata[62:0], resp_err}, 64'd0);
    endtask

    task automatic test_read();
        bus.axi_ar_ready = 1'b1;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0000;
        tick();                                   // T: accept
        req_valid = 1'b0;
        chk("rd ar_valid T+1", {63'd0, bus.axi_ar_valid}, 64'd1);
        chk("rd ar_addr T+1", {32'd0, bus.axi_ar_addr}, 64'h8000_0000);
        chk("rd ar_prot", {61'd0, bus.axi_ar_prot}, 64'd0);
        chk("rd req_ready busy", {63'd0, req_ready}, 64'd0);
        tick();                                   // T+1: ar handshake
        chk("rd ar_valid T+2", {63'd0, bus.axi_ar_valid}, 64'd0);
        chk("rd r_ready T+2", {63'd0, bus.axi_r_ready}, 64'd1);
        bus.axi_r_valid = 1'b1; bus.axi_r_data = 64'h1122_3344_5566_7788; bus.axi_r_resp = RESP_OKAY;
        tick();                                   // T+2: r handshake
        bus.axi_r_valid = 1'b0;
        chk("rd resp_valid T+3", {63'd0, resp_valid}, 64'd1);
        chk("rd resp_rdata", resp_rdata, 64'h1122_3344_5566_7788);
        chk("rd resp_err", {63'd0, resp_err}, 64'd0);
        chk("rd r_ready T+3", {63'd0, bus.axi_r_ready}, 64'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("rd resp_valid done", {63'd0, resp_valid}, 64'd0);
        chk("rd req_ready idle", {63'd0, req_ready}, 64'd1);
    endtask

    task automatic test_write_aw_late();
        bus.axi_aw_ready = 1'b0; bus.axi_w_ready = 1'b1;
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0010;
        req_wdata = 64'h0000_0000_DEAD_BEEF; req_wstrb = 8'h0F;
        tick();                                   // T
        req_valid = 1'b0;
        chk("wr aw_valid T+1", {63'd0, bus.axi_aw_valid}, 64'd1);
        chk("wr w_valid T+1", {63'd0, bus.axi_w_valid}, 64'd1);
        chk("wr aw_addr", {32'd0, bus.axi_aw_addr}, 64'h8000_0010);
        chk("wr w_data", bus.axi_w_data, 64'h0000_0000_DEAD_BEEF);
        chk("wr w_strb", {56'd0, bus.axi_w_strb}, 64'h0F);
        tick();                                   // T+1: W handshake
        chk("wr w_valid T+2", {63'd0, bus.axi_w_valid}, 64'd0);
        chk("wr aw_valid T+2", {63'd0, bus.axi_aw_valid}, 64'd1);
        tick();                                   // T+2
        chk("wr aw_valid T+3", {63'd0, bus.axi_aw_valid}, 64'd1);
        tick();                                   // T+3
        bus.axi_aw_ready = 1'b1;
        chk("wr b_ready T+4", {63'd0, bus.axi_b_ready}, 64'd0);
        chk("wr aw_addr held", {32'd0, bus.axi_aw_addr}, 64'h8000_0010);
        tick();                                   // T+4: AW handshake
        bus.axi_aw_ready = 1'b0;
        chk("wr aw_valid T+5", {63'd0, bus.axi_aw_valid}, 64'd0);
        chk("wr b_ready T+5", {63'd0, bus.axi_b_ready}, 64'd1);
        bus.axi_b_valid = 1'b1; bus.axi_b_resp = RESP_OKAY;
        tick();
        bus.axi_b_valid = 1'b0;
        chk("wr resp_valid", {63'd0, resp_valid}, 64'd1);
        chk("wr resp_err", {63'd0, resp_err}, 64'd0);
        chk("wr resp_rdata zero", resp_rdata, 64'd0);
        chk("wr b_ready after", {63'd0, bus.axi_b_ready}, 64'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_write_same_cycle();
        bus.axi_aw_ready = 1'b1; bus.axi_w_ready = 1'b1;
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h0000_0100;
        req_wdata = 64'hCAFE_0000_0000_0001; req_wstrb = 8'hFF;
        tick();
        req_valid = 1'b0;
        chk("wr2 both valid", {62'd0, bus.axi_aw_valid, bus.axi_w_valid}, 64'd3);
        tick();                                   // both handshakes together
        bus.axi_aw_ready = 1'b0; bus.axi_w_ready = 1'b0;
        chk("wr2 valids drop", {62'd0, bus.axi_aw_valid, bus.axi_w_valid}, 64'd0);
        chk("wr2 b_ready", {63'd0, bus.axi_b_ready}, 64'd1);
        bus.axi_b_valid = 1'b1; bus.axi_b_resp = RESP_SLVERR;
        tick();
        bus.axi_b_valid = 1'b0;
        chk("wr2 resp_valid", {63'd0, resp_valid}, 64'd1);
        chk("wr2 resp_err slverr", {63'd0, resp_err}, 64'd1);
        chk("wr2 single b", {63'd0, bus.axi_b_ready}, 64'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_resp_hold();
        bus.axi_ar_ready = 1'b1;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h0000_0080;
        tick();
        req_valid = 1'b0;
        tick();
        bus.axi_r_valid = 1'b1; bus.axi_r_data = 64'h0000_0000_0000_00A5; bus.axi_r_resp = RESP_DECERR;
        tick();
        bus.axi_r_valid = 1'b0;
        req_valid = 1'b1; req_addr = 32'h0000_0040;
        for (int i = 0; i < 5; i++) begin
            chk("hold resp_valid", {63'd0, resp_valid}, 64'd1);
            chk("hold resp_rdata", resp_rdata, 64'hA5);
            chk("hold resp_err decerr", {63'd0, resp_err}, 64'd1);
            chk("hold req_ready", {63'd0, req_ready}, 64'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();                                   // resp handshake
        resp_ready = 1'b0;
        chk("hold idle req_ready", {63'd0, req_ready}, 64'd1);
        chk("hold idle ar_valid", {63'd0, bus.axi_ar_valid}, 64'd0);
        tick();                                   // new request accepted
        req_valid = 1'b0;
        chk("hold new ar_valid", {63'd0, bus.axi_ar_valid}, 64'd1);
        chk("hold new ar_addr", {32'd0, bus.axi_ar_addr}, 64'h40);
        tick();
        bus.axi_r_valid = 1'b1; bus.axi_r_data = 64'h1; bus.axi_r_resp = RESP_EXOKAY;
        tick();
        bus.axi_r_valid = 1'b0;
        chk("hold exokay err", {63'd0, resp_err}, 64'd1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    task automatic test_ar_stall();
        bus.axi_ar_ready = 1'b0;
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0000;
        tick();
        req_valid = 1'b0;
        req_addr  = 32'h0000_1234;
        for (int i = 0; i < 4; i++) begin
            chk("stall ar_valid", {63'd0, bus.axi_ar_valid}, 64'd1);
            chk("stall ar_addr", {32'd0, bus.axi_ar_addr}, 64'h8000_0000);
            tick();
        end
        bus.axi_ar_ready = 1'b1;
        chk("stall ar_addr hs", {32'd0, bus.axi_ar_addr}, 64'h8000_0000);
        tick();
        bus.axi_ar_ready = 1'b0;
        chk("stall r_ready", {63'd0, bus.axi_r_ready}, 64'd1);
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid valids", {58'd0, bus.axi_aw_valid, bus.axi_w_valid, bus.axi_ar_valid,
                           bus.axi_r_ready, bus.axi_b_ready, resp_valid}, 64'd0);
        chk("mid req_ready", {63'd0, req_ready}, 64'd1);
        chk("mid resp_rdata", resp_rdata, 64'd0);
        bus.axi_r_valid = 1'b1; bus.axi_r_data = 64'hFFFF; bus.axi_r_resp = RESP_OKAY;
        bus.axi_b_valid = 1'b1; bus.axi_b_resp = RESP_SLVERR;
        tick();
        bus.axi_r_valid = 1'b0; bus.axi_b_valid = 1'b0;
        chk("stray r/b ignored", {62'd0, resp_valid, resp_err}, 64'd0);
        chk("stray req_ready", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        resp_ready = 1'b0;
        bus.axi_aw_ready = 1'b0; bus.axi_w_ready = 1'b0;
        bus.axi_b_valid = 1'b0; bus.axi_b_resp = '0;
        bus.axi_ar_ready = 1'b0;
        bus.axi_r_valid = 1'b0; bus.axi_r_data = '0; bus.axi_r_resp = '0;
        test_reset();
        test_read();
        test_write_aw_late();
        test_write_same_cycle();
        test_resp_hold();
        test_ar_stall();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
